// File: rtl/dp_feeder.sv
// ----------------------------------------------------------------------------
// dp_feeder
// Holds PIXEL_N pixel/weight pairs and, on start, sequences a downstream
// dot-product unit: clear it for two cycles, stream the elements PARALLEL
// lanes per beat, wait DRAIN_CYC cycles for the pipeline to settle, then
// capture the unit's running sum as the result.
//
// Ports
//   clk          single clock, rising edge
//   GlobalReset  asynchronous active-low reset
//   wr_en        element write strobe (accepted only in IDLE, addr < PIXEL_N)
//   wr_addr      element index
//   wr_pixel     pixel to store
//   wr_weight    weight to store
//   start        begin a dot product (accepted only in IDLE)
//   busy         high whenever the sequencer is not IDLE
//   done         one-cycle pulse when result is valid
//   result       captured dot-product value, held until the next done
//   dp_clear     active-high clear to the downstream dot-product unit
//   Pixels       lane j at [j*PIXEL_SIZE +: PIXEL_SIZE], zero outside STREAM
//   Weights      lane j at [j*WEIGHT_SIZE +: WEIGHT_SIZE], zero outside STREAM
//   value        running sum from the dot-product unit
// ----------------------------------------------------------------------------
module dp_feeder #(
    parameter int PIXEL_N     = 10,
    parameter int PIXEL_SIZE  = 10,
    parameter int WEIGHT_SIZE = 19,
    parameter int PARALLEL    = 2,
    parameter int VAL_SIZE    = 26,
    parameter int ADDR_W      = 4,
    parameter int DRAIN_CYC   = 12
) (
    input  logic                            clk,
    input  logic                            GlobalReset,
    input  logic                            wr_en,
    input  logic [ADDR_W-1:0]               wr_addr,
    input  logic [PIXEL_SIZE-1:0]           wr_pixel,
    input  logic [WEIGHT_SIZE-1:0]          wr_weight,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic [VAL_SIZE-1:0]             result,
    output logic                            dp_clear,
    output logic [PARALLEL*PIXEL_SIZE-1:0]  Pixels,
    output logic [PARALLEL*WEIGHT_SIZE-1:0] Weights,
    input  logic [VAL_SIZE-1:0]             value
);

    localparam int BEATS   = (PIXEL_N + PARALLEL - 1) / PARALLEL;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam int DEPTH   = 2 ** ADDR_W;

    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(BEATS - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);
    localparam logic [ADDR_W:0]    ELEM_LIM   = (ADDR_W + 1)'(PIXEL_N);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic                           r_clr_cnt;
    logic                           w_clr_cnt_nxt;
    logic [BEAT_W-1:0]              r_beat;
    logic [BEAT_W-1:0]              w_beat_nxt;
    logic [DRAIN_W-1:0]             r_drain;
    logic [DRAIN_W-1:0]             w_drain_nxt;

    logic                           r_busy;
    logic                           r_done;
    logic                           r_dp_clear;
    logic [VAL_SIZE-1:0]            r_result;
    logic [PARALLEL*PIXEL_SIZE-1:0]  r_pixels;
    logic [PARALLEL*WEIGHT_SIZE-1:0] r_weights;

    logic                           w_busy_nxt;
    logic                           w_done_nxt;
    logic                           w_clear_nxt;
    logic [VAL_SIZE-1:0]            w_result_nxt;
    logic [PARALLEL*PIXEL_SIZE-1:0]  w_pixels_nxt;
    logic [PARALLEL*WEIGHT_SIZE-1:0] w_weights_nxt;
    int                             w_idx;

    logic [PIXEL_SIZE-1:0]          r_pix_mem [DEPTH];
    logic [WEIGHT_SIZE-1:0]         r_wgt_mem [DEPTH];
    logic                           w_wr_ok;

    assign w_wr_ok = wr_en && (r_state == S_IDLE) && ({1'b0, wr_addr} < ELEM_LIM);

    // Element storage: deliberately not reset so contents survive GlobalReset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_pix_mem[wr_addr] <= wr_pixel;
            r_wgt_mem[wr_addr] <= wr_weight;
        end
    end

    // State register and sequencing counters.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            r_state   <= S_IDLE;
            r_clr_cnt <= 1'b0;
            r_beat    <= '0;
            r_drain   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
            r_beat    <= w_beat_nxt;
            r_drain   <= w_drain_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_CLEAR;
                else       w_state_nxt = S_IDLE;
            end
            S_CLEAR: begin
                if (r_clr_cnt) w_state_nxt = S_STREAM;
                else           w_state_nxt = S_CLEAR;
            end
            S_STREAM: begin
                if (r_beat == BEAT_LAST) w_state_nxt = S_DRAIN;
                else                     w_state_nxt = S_STREAM;
            end
            S_DRAIN: begin
                if (r_drain == DRAIN_LAST) w_state_nxt = S_DONE;
                else                       w_state_nxt = S_DRAIN;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values for counters and outputs; outputs are derived from the
    // upcoming state so the registered versions line up with the state itself.
    always_comb begin
        if ((r_state == S_CLEAR) && (w_state_nxt == S_CLEAR)) w_clr_cnt_nxt = 1'b1;
        else                                                  w_clr_cnt_nxt = 1'b0;

        // r_beat is the beat being presented; it restarts at 0 on STREAM entry
        // and wraps to 0 when STREAM is left.
        if ((r_state == S_STREAM) && (w_state_nxt == S_STREAM)) w_beat_nxt = r_beat + BEAT_W'(1);
        else                                                    w_beat_nxt = '0;

        if ((r_state == S_DRAIN) && (w_state_nxt == S_DRAIN)) w_drain_nxt = r_drain + DRAIN_W'(1);
        else                                                  w_drain_nxt = '0;

        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_clear_nxt = (w_state_nxt == S_CLEAR);
        w_done_nxt  = (w_state_nxt == S_DONE);

        if (w_state_nxt == S_DONE) w_result_nxt = value;
        else                       w_result_nxt = r_result;

        w_idx         = 0;
        w_pixels_nxt  = '0;
        w_weights_nxt = '0;
        if (w_state_nxt == S_STREAM) begin
            for (int j = 0; j < PARALLEL; j++) begin
                w_idx = int'(w_beat_nxt) * PARALLEL + j;
                // Lanes past the last element are padded with zeros.
                if (w_idx < PIXEL_N) begin
                    w_pixels_nxt[j*PIXEL_SIZE +: PIXEL_SIZE]    = r_pix_mem[w_idx[ADDR_W-1:0]];
                    w_weights_nxt[j*WEIGHT_SIZE +: WEIGHT_SIZE] = r_wgt_mem[w_idx[ADDR_W-1:0]];
                end else begin
                    w_pixels_nxt[j*PIXEL_SIZE +: PIXEL_SIZE]    = '0;
                    w_weights_nxt[j*WEIGHT_SIZE +: WEIGHT_SIZE] = '0;
                end
            end
        end else begin
            w_pixels_nxt  = '0;
            w_weights_nxt = '0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dp_clear <= 1'b0;
            r_result   <= '0;
            r_pixels   <= '0;
            r_weights  <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_dp_clear <= w_clear_nxt;
            r_result   <= w_result_nxt;
            r_pixels   <= w_pixels_nxt;
            r_weights  <= w_weights_nxt;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign dp_clear = r_dp_clear;
    assign result   = r_result;
    assign Pixels   = r_pixels;
    assign Weights  = r_weights;

endmodule

// File: doc/dp_feeder.md
DP_FEEDER -- requirements
Module: dp_feeder

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter PIXEL_N, default 10, giving the elements per dot product.
REQ-002 The block SHALL have parameter PIXEL_SIZE, default 10, giving the pixel width in bits.
REQ-003 The block SHALL have parameter WEIGHT_SIZE, default 19, giving the weight width in bits.
REQ-004 The block SHALL have parameter PARALLEL, default 2, giving the lanes per beat.
REQ-005 The block SHALL have parameter VAL_SIZE, default 26, giving the result width.
REQ-006 The block SHALL have parameter ADDR_W, default 4, giving the element address width, with 2^ADDR_W >= PIXEL_N.
REQ-007 The block SHALL have parameter DRAIN_CYC, default 12, giving the wait in cycles after the last beat before sampling the result.

Ports (name, direction, width, meaning):
REQ-008 The block SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-009 The block SHALL have port GlobalReset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-010 The block SHALL have port wr_en, input, 1 bit: element write strobe.
REQ-011 The block SHALL have port wr_addr, input, ADDR_W bits: element index.
REQ-012 The block SHALL have port wr_pixel, input, PIXEL_SIZE bits: pixel to store.
REQ-013 The block SHALL have port wr_weight, input, WEIGHT_SIZE bits: weight to store.
REQ-014 The block SHALL have port start, input, 1 bit: begin a dot product.
REQ-015 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle pulse when result is valid.
REQ-017 The block SHALL have port result, output, VAL_SIZE bits: captured dot-product value.
REQ-018 The block SHALL have port dp_clear, output, 1 bit: active-high reset to the downstream dot-product unit.
REQ-019 The block SHALL have port Pixels, output, PARALLEL*PIXEL_SIZE bits: lane j at bits [j*PIXEL_SIZE +: PIXEL_SIZE].
REQ-020 The block SHALL have port Weights, output, PARALLEL*WEIGHT_SIZE bits: lane j at bits [j*WEIGHT_SIZE +: WEIGHT_SIZE].
REQ-021 The block SHALL have port value, input, VAL_SIZE bits: running sum from the dot-product unit.

Function
REQ-022 The block SHALL hold PIXEL_N pixel/weight pairs in internal register storage, written when wr_en=1, state=IDLE and wr_addr<PIXEL_N.
REQ-023 The block SHALL ignore writes with wr_addr>=PIXEL_N or state!=IDLE.
REQ-024 The block SHALL have FSM states IDLE, CLEAR, STREAM, DRAIN and DONE.
REQ-025 In IDLE, start=1 SHALL move the FSM to CLEAR, and start SHALL be ignored in every other state.
REQ-026 CLEAR SHALL last exactly 2 cycles with dp_clear=1, then move to STREAM, and dp_clear SHALL be 0 in all other states.
REQ-027 STREAM SHALL last B=ceil(PIXEL_N/PARALLEL) cycles, with beat k (0..B-1) driving lane j with element k*PARALLEL+j on Pixels/Weights.
REQ-028 Any lane whose element index is >=PIXEL_N SHALL be driven with zero pixel and zero weight.
REQ-029 Pixels and Weights SHALL be registered outputs and SHALL be all-zero in every state except STREAM.
REQ-030 DRAIN SHALL last exactly DRAIN_CYC cycles, then move to DONE.
REQ-031 On entry to DONE, result SHALL capture value, done SHALL be 1 for exactly that one cycle, and the FSM SHALL then return to IDLE.
REQ-032 result SHALL hold its value until the next DONE.
REQ-033 busy SHALL be 1 from the cycle after start is accepted through the DONE cycle inclusive.
REQ-034 wr_en and start asserted in the same IDLE cycle SHALL both take effect, and the stream SHALL use the newly written element.
REQ-035 Back-to-back operation SHALL be supported: start asserted in the cycle after done SHALL be accepted.
REQ-036 The beat counter SHALL wrap to 0 on leaving STREAM, and the drain counter SHALL reset to 0 on leaving DRAIN.

Reset
REQ-037 While GlobalReset=0, the block SHALL force state=IDLE, busy=0, done=0, dp_clear=0, result=0, Pixels=0, Weights=0 and all counters to 0, asynchronously and regardless of clk.
REQ-038 Element storage SHALL NOT be cleared by reset.
REQ-039 Reset asserted mid-operation SHALL abandon the operation with no done pulse, and after release the FSM SHALL wait in IDLE for start.

Verification
REQ-040 The bench SHALL cover basic flow: PIXEL_N=10, PARALLEL=2, pixels 1..10, weights all 2, start at cycle 0 -> dp_clear high for cycles 1-2, five beats on cycles 3-7 with beat0 lanes (1,2) and beat4 lanes (9,10), done at cycle 8+DRAIN_CYC, result=110 from a reference dot-product model.
REQ-041 The bench SHALL cover padding: PIXEL_N=5, PARALLEL=2 -> 3 beats, and beat 2 lane 1 Pixels/Weights both 0.
REQ-042 The bench SHALL cover ignored inputs: start and wr_en pulsed during STREAM -> no restart, storage unchanged, exactly one done.
REQ-043 The bench SHALL cover same-cycle write/start: wr_en with wr_addr=0 and wr_pixel=7, plus start, in IDLE -> beat 0 lane 0 pixel = 7.
REQ-044 The bench SHALL cover reset mid-operation: GlobalReset=0 during DRAIN -> all outputs 0 immediately, no done, and the next start completes normally with the correct result.
REQ-045 The bench SHALL cover back-to-back operation: start in the cycle after done -> second operation's dp_clear appears next cycle and its result matches.
